// File: rtl/axil_rr_arb_pkg.sv
// Shared types and helpers for the two-master AXI-Lite round-robin arbiter.
// Latency: n/a (types, constants and a pure combinational function).
// Backpressure: n/a.
package axil_rr_arb_pkg;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_ADDR = 2'd1,
      WR_RESP = 2'd2
   } wr_state_t;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_ADDR = 2'd1,
      RD_DATA = 2'd2
   } rd_state_t;

   localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

   // One-hot grant for two requesters. On contention the master that did
   // not complete last wins; a lone requester always wins.
   function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
      logic [1:0] gnt;
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
      return gnt;
   endfunction

endpackage

// File: rtl/axil_rr_arb_sel.sv
// 2-way round-robin selector holding the last-served pointer for one path.
// Latency: pick is combinational from req; pointer updates on the edge after upd.
// Backpressure: none; caller decides when to sample pick and when to strobe upd.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset (pointer resets to 1)
//   req[1:0]    : per-master request
//   upd         : completion strobe, loads upd_idx into the pointer
//   upd_idx     : index of the master that just completed
//   pick[1:0]   : one-hot grant suggestion for the current req
module axil_rr_arb_sel
   import axil_rr_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       upd,
   input  logic       upd_idx,
   output logic [1:0] pick
);

   logic last;

   // Reset to 1 so master 0 wins the first contention.
   always_ff @(posedge clk) begin
      if (reset) begin
         last <= 1'b1;
      end else if (upd) begin
         last <= upd_idx;
      end
   end

   assign pick = rr_pick(req, last);

endmodule

// File: rtl/axil_rr_arb.sv
// Two-master to one-slave AXI-Lite arbiter, independent round-robin read and write paths.
// Latency: grant registered the cycle after a request; readys/responses are combinational pass-throughs.
// Backpressure: one outstanding transaction per path; the non-granted master sees readys/valids low.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   m_aw*/m_w*/m_b*[2]    : per-master write address, write data, write response
//   m_ar*/m_r*[2]         : per-master read address, read data
//   s_aw*/s_w*/s_b*       : slave write channels
//   s_ar*/s_r*            : slave read channels
//   wr_gnt, rd_gnt        : one-hot grants, 0 while the path is idle
module axil_rr_arb
   import axil_rr_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                              clk,
   input  logic                              reset,
   // master side
   input  logic [1:0][ADDR_WIDTH-1:0]        m_awaddr,
   input  logic [1:0][2:0]                   m_awprot,
   input  logic [1:0]                        m_awvalid,
   output logic [1:0]                        m_awready,
   input  logic [1:0][DATA_WIDTH-1:0]        m_wdata,
   input  logic [1:0][DATA_WIDTH/8-1:0]      m_wstrb,
   input  logic [1:0]                        m_wvalid,
   output logic [1:0]                        m_wready,
   output logic [1:0][1:0]                   m_bresp,
   output logic [1:0]                        m_bvalid,
   input  logic [1:0]                        m_bready,
   input  logic [1:0][ADDR_WIDTH-1:0]        m_araddr,
   input  logic [1:0][2:0]                   m_arprot,
   input  logic [1:0]                        m_arvalid,
   output logic [1:0]                        m_arready,
   output logic [1:0][DATA_WIDTH-1:0]        m_rdata,
   output logic [1:0][1:0]                   m_rresp,
   output logic [1:0]                        m_rvalid,
   input  logic [1:0]                        m_rready,
   // slave side
   output logic [ADDR_WIDTH-1:0]             s_awaddr,
   output logic [2:0]                        s_awprot,
   output logic                              s_awvalid,
   input  logic                              s_awready,
   output logic [DATA_WIDTH-1:0]             s_wdata,
   output logic [DATA_WIDTH/8-1:0]           s_wstrb,
   output logic                              s_wvalid,
   input  logic                              s_wready,
   input  logic [1:0]                        s_bresp,
   input  logic                              s_bvalid,
   output logic                              s_bready,
   output logic [ADDR_WIDTH-1:0]             s_araddr,
   output logic [2:0]                        s_arprot,
   output logic                              s_arvalid,
   input  logic                              s_arready,
   input  logic [DATA_WIDTH-1:0]             s_rdata,
   input  logic [1:0]                        s_rresp,
   input  logic                              s_rvalid,
   output logic                              s_rready,
   // grants
   output logic [1:0]                        wr_gnt,
   output logic [1:0]                        rd_gnt
);

   // ---------------------------------------------------------------- write path
   wr_state_t  wr_state;
   logic       aw_done;
   logic       w_done;
   logic       wr_idx;
   logic       wr_act;
   logic [1:0] wr_req;
   logic [1:0] wr_pick;
   logic       aw_hs;
   logic       w_hs;
   logic       b_hs;

   assign wr_idx = wr_gnt[1];
   assign wr_act = |wr_gnt;
   assign wr_req = m_awvalid | m_wvalid;
   assign aw_hs  = s_awvalid & s_awready;
   assign w_hs   = s_wvalid & s_wready;
   // s_bready is only raised in WR_RESP, so this is exactly the completion event.
   assign b_hs   = s_bvalid & s_bready;

   axil_rr_arb_sel u_wr_sel (
      .clk     (clk),
      .reset   (reset),
      .req     (wr_req),
      .upd     (b_hs),
      .upd_idx (wr_idx),
      .pick    (wr_pick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_state <= WR_IDLE;
         wr_gnt   <= 2'b00;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
      end else begin
         case (wr_state)
            WR_IDLE: begin
               if (|wr_req) begin
                  wr_gnt   <= wr_pick;
                  wr_state <= WR_ADDR;
               end
            end
            WR_ADDR: begin
               if (aw_hs) aw_done <= 1'b1;
               if (w_hs)  w_done  <= 1'b1;
               // AW and W may finish in either order or together.
               if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                  wr_state <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (b_hs) begin
                  aw_done  <= 1'b0;
                  w_done   <= 1'b0;
                  wr_gnt   <= 2'b00;
                  wr_state <= WR_IDLE;
               end
            end
            default: begin
               wr_state <= WR_IDLE;
               wr_gnt   <= 2'b00;
               aw_done  <= 1'b0;
               w_done   <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      s_awaddr  = '0;
      s_awprot  = '0;
      s_awvalid = 1'b0;
      s_wdata   = '0;
      s_wstrb   = '0;
      s_wvalid  = 1'b0;
      s_bready  = 1'b0;
      m_awready = 2'b00;
      m_wready  = 2'b00;
      m_bvalid  = 2'b00;
      for (int i = 0; i < 2; i++) m_bresp[i] = AXIL_RESP_OKAY;
      if (wr_act) begin
         s_awaddr  = m_awaddr[wr_idx];
         s_awprot  = m_awprot[wr_idx];
         s_wdata   = m_wdata[wr_idx];
         s_wstrb   = m_wstrb[wr_idx];
         // done flags mask the channel once its beat has been accepted
         s_awvalid = m_awvalid[wr_idx] & ~aw_done;
         s_wvalid  = m_wvalid[wr_idx] & ~w_done;
         s_bready  = (wr_state == WR_RESP) & m_bready[wr_idx];
         m_awready[wr_idx] = s_awready & ~aw_done;
         m_wready[wr_idx]  = s_wready & ~w_done;
         m_bvalid[wr_idx]  = (wr_state == WR_RESP) & s_bvalid;
         m_bresp[wr_idx]   = s_bresp;
      end
   end

   // ----------------------------------------------------------------- read path
   rd_state_t  rd_state;
   logic       ar_done;
   logic       rd_idx;
   logic       rd_act;
   logic [1:0] rd_pick;
   logic       ar_hs;
   logic       r_hs;

   assign rd_idx = rd_gnt[1];
   assign rd_act = |rd_gnt;
   assign ar_hs  = s_arvalid & s_arready;
   assign r_hs   = s_rvalid & s_rready;

   axil_rr_arb_sel u_rd_sel (
      .clk     (clk),
      .reset   (reset),
      .req     (m_arvalid),
      .upd     (r_hs),
      .upd_idx (rd_idx),
      .pick    (rd_pick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_state <= RD_IDLE;
         rd_gnt   <= 2'b00;
         ar_done  <= 1'b0;
      end else begin
         case (rd_state)
            RD_IDLE: begin
               if (|m_arvalid) begin
                  rd_gnt   <= rd_pick;
                  rd_state <= RD_ADDR;
               end
            end
            RD_ADDR: begin
               if (ar_hs) begin
                  ar_done  <= 1'b1;
                  rd_state <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (r_hs) begin
                  ar_done  <= 1'b0;
                  rd_gnt   <= 2'b00;
                  rd_state <= RD_IDLE;
               end
            end
            default: begin
               rd_state <= RD_IDLE;
               rd_gnt   <= 2'b00;
               ar_done  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      s_araddr  = '0;
      s_arprot  = '0;
      s_arvalid = 1'b0;
      s_rready  = 1'b0;
      m_arready = 2'b00;
      m_rvalid  = 2'b00;
      m_rdata   = '0;
      for (int i = 0; i < 2; i++) m_rresp[i] = AXIL_RESP_OKAY;
      if (rd_act) begin
         s_araddr  = m_araddr[rd_idx];
         s_arprot  = m_arprot[rd_idx];
         s_arvalid = m_arvalid[rd_idx] & ~ar_done;
         s_rready  = (rd_state == RD_DATA) & m_rready[rd_idx];
         m_arready[rd_idx] = s_arready & ~ar_done;
         m_rvalid[rd_idx]  = (rd_state == RD_DATA) & s_rvalid;
         m_rdata[rd_idx]   = s_rdata;
         m_rresp[rd_idx]   = s_rresp;
      end
   end

endmodule

// File: tb/tb_axil_rr_arb.sv
// Directed bench for axil_rr_arb: behavioural slave, two master agents, grant monitor.
// Inputs change 1ns after the rising edge; everything is sampled on the falling edge.
// The slave answers a read with rdata equal to the read address.
`timescale 1ns/1ps
module tb_axil_rr_arb;
   import axil_rr_arb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic [1:0][AW-1:0]   m_awaddr;
   logic [1:0][2:0]      m_awprot;
   logic [1:0]           m_awvalid, m_awready;
   logic [1:0][DW-1:0]   m_wdata;
   logic [1:0][DW/8-1:0] m_wstrb;
   logic [1:0]           m_wvalid, m_wready;
   logic [1:0][1:0]      m_bresp;
   logic [1:0]           m_bvalid, m_bready;
   logic [1:0][AW-1:0]   m_araddr;
   logic [1:0][2:0]      m_arprot;
   logic [1:0]           m_arvalid, m_arready;
   logic [1:0][DW-1:0]   m_rdata;
   logic [1:0][1:0]      m_rresp;
   logic [1:0]           m_rvalid, m_rready;

   logic [AW-1:0]   s_awaddr;
   logic [2:0]      s_awprot;
   logic            s_awvalid, s_awready;
   logic [DW-1:0]   s_wdata;
   logic [DW/8-1:0] s_wstrb;
   logic            s_wvalid, s_wready;
   logic [1:0]      s_bresp;
   logic            s_bvalid, s_bready;
   logic [AW-1:0]   s_araddr;
   logic [2:0]      s_arprot;
   logic            s_arvalid, s_arready;
   logic [DW-1:0]   s_rdata;
   logic [1:0]      s_rresp;
   logic            s_rvalid, s_rready;
   logic [1:0]      wr_gnt, rd_gnt;

   axil_rr_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset),
      .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .wr_gnt(wr_gnt), .rd_gnt(rd_gnt)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------ slave model
   logic [1:0]  slv_bresp;
   logic [31:0] slv_awaddr, slv_wdata;
   logic [3:0]  slv_wstrb;

   initial begin
      logic got_aw, got_w, aw_hs, w_hs, b_hs, ar_hs, r_hs, rst_s;
      logic [31:0] ar_addr;
      got_aw = 1'b0; got_w = 1'b0; ar_addr = '0;
      slv_awaddr = '0; slv_wdata = '0; slv_wstrb = '0;
      s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
      s_bvalid = 1'b0; s_bresp = AXIL_RESP_OKAY;
      s_rvalid = 1'b0; s_rdata = '0; s_rresp = AXIL_RESP_OKAY;
      forever begin
         @(negedge clk);
         aw_hs = s_awvalid & s_awready;
         w_hs  = s_wvalid & s_wready;
         b_hs  = s_bvalid & s_bready;
         ar_hs = s_arvalid & s_arready;
         r_hs  = s_rvalid & s_rready;
         rst_s = reset;
         if (aw_hs) slv_awaddr = s_awaddr;
         if (w_hs) begin slv_wdata = s_wdata; slv_wstrb = s_wstrb; end
         if (ar_hs) ar_addr = s_araddr;
         @(posedge clk); #1;
         if (rst_s) begin
            got_aw = 1'b0; got_w = 1'b0; s_bvalid = 1'b0; s_rvalid = 1'b0;
         end else begin
            if (b_hs) s_bvalid = 1'b0;
            if (aw_hs) got_aw = 1'b1;
            if (w_hs) got_w = 1'b1;
            if (got_aw && got_w && !s_bvalid) begin
               s_bvalid = 1'b1; s_bresp = slv_bresp; got_aw = 1'b0; got_w = 1'b0;
            end
            if (r_hs) s_rvalid = 1'b0;
            if (ar_hs) begin s_rvalid = 1'b1; s_rdata = ar_addr; s_rresp = AXIL_RESP_OKAY; end
         end
      end
   end

   // --------------------------------------------------------- grant monitor
   logic [1:0] wr_q[$];
   logic [1:0] rd_q[$];
   int rd_gnt_cyc[$];
   int r_hs_cyc[$];

   initial begin
      logic [1:0] prev_wr, prev_rd;
      prev_wr = 2'b00; prev_rd = 2'b00;
      forever begin
         @(negedge clk);
         if (wr_gnt != 2'b00 && prev_wr == 2'b00) wr_q.push_back(wr_gnt);
         if (rd_gnt != 2'b00 && prev_rd == 2'b00) begin
            rd_q.push_back(rd_gnt);
            rd_gnt_cyc.push_back(cyc);
         end
         if (s_rvalid & s_rready) r_hs_cyc.push_back(cyc);
         prev_wr = wr_gnt; prev_rd = rd_gnt;
      end
   end

   // ---------------------------------------------------------- master agents
   task automatic m_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int w_dly, output logic [1:0] resp);
      logic w_p, b_got, aw_hs, w_hs, b_hs;
      int n;
      w_p = 1'b1; b_got = 1'b0; n = 0; resp = 2'b11;
      m_awaddr[m] = addr; m_awprot[m] = 3'd0; m_awvalid[m] = 1'b1;
      m_wdata[m] = data; m_wstrb[m] = strb; m_wvalid[m] = (w_dly == 0);
      while (!b_got && n < 200) begin
         @(negedge clk);
         aw_hs = m_awvalid[m] & m_awready[m];
         w_hs  = m_wvalid[m] & m_wready[m];
         b_hs  = m_bvalid[m] & m_bready[m];
         if (b_hs) resp = m_bresp[m];
         @(posedge clk); #1;
         n++;
         if (aw_hs) m_awvalid[m] = 1'b0;
         if (w_hs) begin m_wvalid[m] = 1'b0; w_p = 1'b0; end
         if (w_p && !m_wvalid[m] && n >= w_dly) m_wvalid[m] = 1'b1;
         if (b_hs) b_got = 1'b1;
      end
      chk($sformatf("wr_done_m%0d", m), 32'(b_got), 32'h1);
   endtask

   task automatic m_read(input int m, input logic [31:0] addr,
                         output logic [31:0] data, output logic [1:0] resp);
      logic ar_hs, r_hs, r_got;
      int n;
      r_got = 1'b0; n = 0; data = '0; resp = 2'b11;
      m_araddr[m] = addr; m_arprot[m] = 3'd0; m_arvalid[m] = 1'b1;
      while (!r_got && n < 200) begin
         @(negedge clk);
         ar_hs = m_arvalid[m] & m_arready[m];
         r_hs  = m_rvalid[m] & m_rready[m];
         if (r_hs) begin data = m_rdata[m]; resp = m_rresp[m]; end
         @(posedge clk); #1;
         n++;
         if (ar_hs) m_arvalid[m] = 1'b0;
         if (r_hs) r_got = 1'b1;
      end
      chk($sformatf("rd_done_m%0d", m), 32'(r_got), 32'h1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------- sequence
   initial begin
      logic [31:0] d0, d1;
      logic [1:0]  rs0, rs1;
      int n_m0;
      reset = 1'b1;
      m_awaddr = '0; m_awprot = '0; m_awvalid = '0;
      m_wdata = '0; m_wstrb = '0; m_wvalid = '0;
      m_araddr = '0; m_arprot = '0; m_arvalid = '0;
      m_bready = 2'b11; m_rready = 2'b11;
      slv_bresp = AXIL_RESP_OKAY;
      repeat (3) tick();
      reset = 1'b0;

      // reset state
      @(negedge clk);
      chk("rst_wr_gnt", 32'(wr_gnt), 32'h0);
      chk("rst_rd_gnt", 32'(rd_gnt), 32'h0);
      chk("rst_s_vld", 32'({s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}), 32'h0);
      chk("rst_m_rdy", 32'({m_awready, m_wready, m_arready, m_bvalid, m_rvalid}), 32'h0);

      // single write from m0
      tick();
      m_awaddr[0] = 32'h10; m_awvalid[0] = 1'b1;
      m_wdata[0] = 32'hDEADBEEF; m_wstrb[0] = 4'hF; m_wvalid[0] = 1'b1;
      @(negedge clk);
      chk("t1_gnt_req_cyc", 32'(wr_gnt), 32'h0);
      tick(); @(negedge clk);
      chk("t1_gnt", 32'(wr_gnt), 32'h1);
      chk("t1_s_vld", 32'({s_awvalid, s_wvalid}), 32'h3);
      chk("t1_s_awaddr", s_awaddr, 32'h10);
      chk("t1_s_wdata", s_wdata, 32'hDEADBEEF);
      chk("t1_s_wstrb", 32'(s_wstrb), 32'hF);
      chk("t1_m_rdy", 32'({m_awready, m_wready}), 32'h5);
      tick();
      m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b0;
      @(negedge clk);
      chk("t1_bvalid", 32'(m_bvalid), 32'h1);
      chk("t1_bresp", 32'(m_bresp[0]), 32'(AXIL_RESP_OKAY));
      chk("t1_s_vld_off", 32'({s_awvalid, s_wvalid}), 32'h0);
      chk("t1_m1_rdy", 32'({m_awready[1], m_wready[1], m_bvalid[1]}), 32'h0);
      tick(); @(negedge clk);
      chk("t1_gnt_idle", 32'(wr_gnt), 32'h0);
      chk("t1_slv_awaddr", slv_awaddr, 32'h10);
      chk("t1_slv_wdata", slv_wdata, 32'hDEADBEEF);

      // read contention, read pointer still at reset value
      tick();
      rd_q.delete(); rd_gnt_cyc.delete(); r_hs_cyc.delete();
      fork
         m_read(0, 32'h1111, d0, rs0);
         m_read(1, 32'h2222, d1, rs1);
      join
      chk("t2_rdata_m0", d0, 32'h1111);
      chk("t2_rdata_m1", d1, 32'h2222);
      chk("t2_rresp_m0", 32'(rs0), 32'(AXIL_RESP_OKAY));
      chk("t2_n_gnt", rd_q.size(), 32'd2);
      chk("t2_first", 32'((rd_q.size() > 0) ? rd_q[0] : 2'b00), 32'h1);
      chk("t2_second", 32'((rd_q.size() > 1) ? rd_q[1] : 2'b00), 32'h2);
      chk("t2_gap", (rd_gnt_cyc.size() > 1 && r_hs_cyc.size() > 0) ?
                    32'(rd_gnt_cyc[1] - r_hs_cyc[0]) : 32'hFFFF_FFFF, 32'd2);

      // split AW / W from m1, slave answers SLVERR
      slv_bresp = AXIL_RESP_SLVERR;
      m_awaddr[1] = 32'h20; m_awvalid[1] = 1'b1;
      @(negedge clk);
      tick(); @(negedge clk);
      chk("t3_gnt", 32'(wr_gnt), 32'h2);
      chk("t3_s_vld_aw", 32'({s_awvalid, s_wvalid}), 32'h2);
      tick();
      m_awvalid[1] = 1'b0;
      @(negedge clk);
      chk("t3_aw_drop", 32'(s_awvalid), 32'h0);
      tick(); tick(); @(negedge clk);
      chk("t3_wait_gnt", 32'(wr_gnt), 32'h2);
      chk("t3_wait_bready", 32'({s_bready, m_bvalid}), 32'h0);
      tick();
      m_wdata[1] = 32'hCAFEF00D; m_wstrb[1] = 4'h3; m_wvalid[1] = 1'b1;
      @(negedge clk);
      chk("t3_w_vld", 32'({s_wvalid, m_wready}), 32'h6);
      chk("t3_w_bready", 32'(s_bready), 32'h0);
      tick();
      m_wvalid[1] = 1'b0;
      @(negedge clk);
      chk("t3_bvalid", 32'(m_bvalid), 32'h2);
      chk("t3_bready", 32'(s_bready), 32'h1);
      chk("t3_bresp", 32'(m_bresp[1]), 32'(AXIL_RESP_SLVERR));
      chk("t3_slv_wdata", slv_wdata, 32'hCAFEF00D);
      chk("t3_slv_wstrb", 32'(slv_wstrb), 32'h3);
      tick(); @(negedge clk);
      chk("t3_gnt_idle", 32'(wr_gnt), 32'h0);
      slv_bresp = AXIL_RESP_OKAY;

      // fairness: 8 back-to-back writes per master, m1 completed last
      tick();
      wr_q.delete();
      fork
         begin
            logic [1:0] r;
            for (int k = 0; k < 8; k++) m_write(0, 32'h100 + 32'(k) * 4, 32'hA000_0000 + 32'(k), 4'hF, 0, r);
         end
         begin
            logic [1:0] r;
            for (int k = 0; k < 8; k++) m_write(1, 32'h200 + 32'(k) * 4, 32'hB000_0000 + 32'(k), 4'hF, 0, r);
         end
      join
      chk("t5_n_gnt", wr_q.size(), 32'd16);
      n_m0 = 0;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("t5_order_%0d", i), 32'((wr_q.size() > i) ? wr_q[i] : 2'b00),
             (i % 2 == 0) ? 32'h1 : 32'h2);
         if (i < 8 && wr_q.size() > i && wr_q[i] == 2'b01) n_m0++;
      end
      chk("t5_m0_in_first8", n_m0, 32'd4);

      // concurrent write (m0) and read (m1)
      m_awaddr[0] = 32'h30; m_awvalid[0] = 1'b1;
      m_wdata[0] = 32'h12345678; m_wstrb[0] = 4'hF; m_wvalid[0] = 1'b1;
      m_araddr[1] = 32'h2222; m_arvalid[1] = 1'b1;
      @(negedge clk);
      tick(); @(negedge clk);
      chk("t4_gnts", 32'({wr_gnt, rd_gnt}), 32'h6);
      tick();
      m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b0; m_arvalid[1] = 1'b0;
      @(negedge clk);
      chk("t4_resp_vld", 32'({m_bvalid, m_rvalid}), 32'h6);
      chk("t4_rdata", m_rdata[1], 32'h2222);
      tick(); @(negedge clk);
      chk("t4_idle", 32'({wr_gnt, rd_gnt}), 32'h0);

      // reset while m1 sits in the read data phase; m0 completed the read before
      tick();
      m_read(0, 32'h1111, d0, rs0);
      chk("t6_pre_rdata", d0, 32'h1111);
      m_rready = 2'b00;
      m_araddr[1] = 32'h2222; m_arvalid[1] = 1'b1;
      @(negedge clk);
      tick(); @(negedge clk);
      chk("t6_gnt", 32'(rd_gnt), 32'h2);
      tick();
      m_arvalid[1] = 1'b0;
      @(negedge clk);
      chk("t6_rvalid", 32'(m_rvalid), 32'h2);
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("t6_gnt_in_rst", 32'(rd_gnt), 32'h2);
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("t6_rd_gnt_0", 32'({wr_gnt, rd_gnt}), 32'h0);
      chk("t6_outs_0", 32'({m_rvalid, m_arready, s_arvalid, s_rready, m_bvalid, s_bready}), 32'h0);
      tick();
      m_rready = 2'b11;
      rd_q.delete();
      fork
         m_read(0, 32'h1111, d0, rs0);
         m_read(1, 32'h2222, d1, rs1);
      join
      chk("t6_post_first", 32'((rd_q.size() > 0) ? rd_q[0] : 2'b00), 32'h1);
      chk("t6_post_rdata_m1", d1, 32'h2222);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axil_rr_arb.md
# axil_rr_arb

Two-master to one-slave AXI-Lite arbiter with round-robin grant, used in the AXI-Lite self-test bench to share one `uvma_axil_if` slave between two active master agents. Read and write paths are arbitrated independently, each allowing one outstanding transaction. Responses are routed back to the granted master. All slave-side valids and master-side readys are gated by the grant, so the non-granted master always sees readys low.

## Interface
- `ADDR_WIDTH`, default 32: AW/AR address width.
- `DATA_WIDTH`, default 32: W/R data width, multiple of 8; strobe width is `DATA_WIDTH/8`.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `m_aw*`  in/out  [2]  per-master AW: `awaddr`[ADDR_WIDTH], `awprot`[3], `awvalid` in; `awready` out.
- `m_w*`  in/out  [2]  per-master W: `wdata`, `wstrb`, `wvalid` in; `wready` out.
- `m_b*`  out/in  [2]  per-master B: `bresp`[2], `bvalid` out; `bready` in.
- `m_ar*`  in/out  [2]  per-master AR: `araddr`, `arprot`, `arvalid` in; `arready` out.
- `m_r*`  out/in  [2]  per-master R: `rdata`, `rresp`[2], `rvalid` out; `rready` in.
- `s_aw*`, `s_w*`, `s_b*`, `s_ar*`, `s_r*`  mirrored  single slave side, same field widths.
- `wr_gnt`  out  2  one-hot write grant; 0 when the write path is idle.
- `rd_gnt`  out  2  one-hot read grant; 0 when the read path is idle.

## Operation
- **Write FSM** `WR_IDLE -> WR_ADDR -> WR_RESP -> WR_IDLE`.
  - `WR_IDLE`: a request is `m_awvalid[i] | m_wvalid[i]`. If any request is present, register the grant and go to `WR_ADDR`.
  - `WR_ADDR`: forward the granted AW and W channels. Sticky `aw_done` / `w_done` flags set on each slave handshake; the two may complete in the same or different cycles. Once both are set, go to `WR_RESP`.
  - `WR_RESP`: route `s_b*` to the granted master. On `s_bvalid & m_bready[g]`, clear the flags, update the pointer and return to `WR_IDLE`.
- **Read FSM** `RD_IDLE -> RD_ADDR -> RD_DATA -> RD_IDLE`. Same scheme using `arvalid`, then the R handshake.
- **Round-robin**: a 1-bit `last` pointer per path, reset to 1, so master 0 wins the first contention.
  - If both masters request, grant `~last`. If only one requests, grant it.
  - `last <= g` on completion of the response handshake only.
- **Gating**:
  - Non-granted master's `*ready` is 0 and its `bvalid`/`rvalid` is 0.
  - Slave `*valid` = granted master `valid & ~done`.
  - Slave payloads follow the granted master, or are 0 when there is no grant.
- Read and write paths are fully concurrent. Master 0 may hold the write grant while master 1 holds the read grant.
- A master deasserting valid before its handshake is a protocol violation and is not handled.

## Timing
- **Reset**: all `s_*valid`, `s_bready`, `s_rready`, `m_*ready`, `m_bvalid`, `m_rvalid`, `wr_gnt` and `rd_gnt` are 0. FSMs are IDLE, flags are 0, `last` is 1.
- **Grant latency**: a request seen in cycle N sets the grant in cycle N+1. The slave valid is asserted in N+1, combinationally from the registered grant.
- **Ready/response path**: `m_*ready` and `m_bvalid`/`m_rvalid` are combinational pass-throughs from the slave, gated by grant. There is no added latency after the grant.
- **Back-to-back**:
  - Completion in cycle N means IDLE in N+1, a new grant in N+2. Minimum 1 idle cycle between transactions on a path.
  - With both masters continuously requesting, grants alternate strictly.
- **Reset mid-transaction**: FSMs return to IDLE the next edge and all gated outputs drop. Slave-side in-flight state is not tracked.
- **Same-cycle AW and W handshake**: both flags set and the FSM moves to `WR_RESP` next cycle. `s_bvalid` arriving early is not possible per protocol and is ignored outside `WR_RESP`.

## Structure
- **Package** `axil_rr_arb_pkg` holds:
  - `wr_state_t` and `rd_state_t` enums.
  - `AXIL_RESP_OKAY`/`SLVERR` constants.
  - Function `rr_pick(req[1:0], last)`, returning a one-hot grant.
- **Sub-module** `axil_rr_arb_sel`: 2-way round-robin selector with the `last` register and update strobe. Instantiated once per path.
- Top level holds the two FSMs and the muxing.

## Test plan
- **Single write**: m0 writes `addr 0x10`, `data 0xDEADBEEF`, `strb 0xF`.
  - `wr_gnt = 01` one cycle later; slave sees an identical AW/W.
  - m0 receives `bresp 0`; m1 readys stay 0 throughout.
- **Contention**: m0 and m1 both issue AR in the same cycle after reset.
  - m0 is served first; m1 is granted 2 cycles after m0's R handshake.
  - Each receives its own `rdata` (0x1111 / 0x2222).
- **Split AW/W**: m1 presents AW at cycle 0 and W at cycle 5.
  - FSM stays in `WR_ADDR`; `s_awvalid` drops after its handshake.
  - `WR_RESP` is entered only after the W handshake.
- **Concurrency**: m0 writes while m1 reads at the same time.
  - `wr_gnt = 01` and `rd_gnt = 10` simultaneously; both complete independently.
- **Fairness**: both masters issue 8 back-to-back writes.
  - Grant order is strictly 0,1,0,1,…; each master is served 4 of the first 8.
- **Reset mid-read**: assert `reset` while in `RD_DATA`.
  - Next cycle all outputs are 0 and `rd_gnt = 0`.
  - First post-reset contention grants m0.
